// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave with a 256 x 16-bit register file and a 16-bit LED latch.
// Each frame is a 16-bit command word followed by a 16-bit data word. The pins are
// asynchronous and are synchronised into clk before any decoding.
module spi_slave (
    input  logic        clk,
    input  logic        rst_btn,
    input  logic        spi_sclk_in,
    input  logic        spi_mosi_in,
    input  logic        spi_cs_n_in,
    output logic        spi_miso_out,
    output logic [15:0] led
);

    // Synchroniser chains. SCLK has one extra stage that serves as edge-detect history.
    logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic        mosi_meta_r, mosi_sync_r;
    logic        cs_meta_r, cs_sync_r;

    // Frame state
    logic [5:0]  bit_cnt_r;
    logic [15:0] shift_in_r;
    logic [7:0]  addr_r;
    logic        rd_r;
    logic [15:0] shift_out_r;
    logic [15:0] regs_r [256];

    // Decoded strobes
    logic        sclk_rise_s;
    logic        step_s;
    logic [15:0] word_next_s;
    logic        cmd_done_s;
    logic        last_bit_s;
    logic        rd_shift_s;
    logic [15:0] rd_word_s;

    // Two-flop synchronisers; CS_N rests high so its flops reset to 1.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
        end else begin
            sclk_meta_r <= spi_sclk_in;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            mosi_meta_r <= spi_mosi_in;
            mosi_sync_r <= mosi_meta_r;
            cs_meta_r   <= spi_cs_n_in;
            cs_sync_r   <= cs_meta_r;
        end
    end

    // Edge detection and frame-position decode. MOSI is taken from the stage that
    // lines up with the SCLK edge detect so both see the same pin-sampling instant.
    always_comb begin
        sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
        step_s      = sclk_rise_s & ~cs_sync_r & (bit_cnt_r < 6'd32);
        word_next_s = {shift_in_r[14:0], mosi_sync_r};
        cmd_done_s  = step_s & (bit_cnt_r == 6'd15);
        last_bit_s  = step_s & (bit_cnt_r == 6'd31);
        rd_shift_s  = step_s & rd_r & (bit_cnt_r >= 6'd16) & (bit_cnt_r <= 6'd30);
        // The address is not latched yet on the 16th rise, so index with the incoming word.
        rd_word_s   = regs_r[word_next_s[10:3]];
    end

    // Bit counter, input shifter, and command latch (address + direction at bit 16).
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            bit_cnt_r  <= 6'd0;
            shift_in_r <= 16'h0000;
            addr_r     <= 8'h00;
            rd_r       <= 1'b0;
        end else if (cs_sync_r) begin
            bit_cnt_r  <= 6'd0;
        end else if (step_s) begin
            shift_in_r <= word_next_s;
            bit_cnt_r  <= bit_cnt_r + 6'd1;
            if (cmd_done_s) begin
                addr_r <= word_next_s[10:3];
                rd_r   <= word_next_s[1];
            end
        end
    end

    // Register file and LED latch; only a completed write frame commits.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            for (int i = 0; i < 256; i++) begin
                regs_r[i] <= 16'h0000;
            end
            led <= 16'h0000;
        end else if (last_bit_s && !rd_r) begin
            regs_r[addr_r] <= word_next_s;
            led            <= word_next_s;
        end
    end

    // Read shift-out path; MISO is forced low outside the data phase of a read.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            shift_out_r  <= 16'h0000;
            spi_miso_out <= 1'b0;
        end else if (cs_sync_r) begin
            shift_out_r  <= 16'h0000;
            spi_miso_out <= 1'b0;
        end else if (cmd_done_s) begin
            if (word_next_s[1]) begin
                shift_out_r  <= rd_word_s;
                spi_miso_out <= rd_word_s[15];
            end else begin
                shift_out_r  <= 16'h0000;
                spi_miso_out <= 1'b0;
            end
        end else if (rd_shift_s) begin
            shift_out_r  <= {shift_out_r[14:0], 1'b0};
            spi_miso_out <= shift_out_r[14];
        end else if (step_s) begin
            shift_out_r  <= 16'h0000;
            spi_miso_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master with scoreboard queues for read data and LED updates.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst_btn;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        spi_miso_out;
    logic [15:0] led;

    int          checks = 0;
    int          failures = 0;

    logic [15:0] rd_q [$];
    logic [15:0] led_q [$];
    logic        rd_valid = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        mon_en = 1'b0;
    logic [15:0] led_prev = 16'h0000;

    spi_slave dut (
        .clk          (clk),
        .rst_btn      (rst_btn),
        .spi_sclk_in  (sclk),
        .spi_mosi_in  (mosi),
        .spi_cs_n_in  (cs_n),
        .spi_miso_out (spi_miso_out),
        .led          (led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_cmd(input logic [7:0] a, input logic r,
                                           input logic [4:0] hi, input logic b2, input logic b0);
        return {hi, a, b2, r, b0};
    endfunction

    // Read-data monitor: compares each captured read word with the oldest expectation.
    always @(posedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", rd_data, 16'hDEAD);
            end else begin
                check("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    // LED monitor: every change of led must match the next queued expectation.
    always @(posedge clk) begin
        if (mon_en && (led !== led_prev)) begin
            if (led_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL led_unexpected: got %h expected no change from %h", led, led_prev);
            end else begin
                check("led_update", led, led_q.pop_front());
            end
        end
        led_prev = led;
    end

    task automatic shift_bits(input logic [15:0] cmd, input logic [15:0] data,
                              input int nbits, input int half, output logic [15:0] cap);
        logic [31:0] fr;
        fr  = {cmd, data};
        cap = 16'h0000;
        for (int i = 0; i < nbits; i++) begin
            mosi = fr[31-i];
            repeat (half) @(negedge clk);
            if (i >= 16) cap[31-i] = spi_miso_out;
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic begin_frame();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic end_frame();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_write(input logic [15:0] cmd, input logic [15:0] d);
        logic [15:0] cap;
        led_q.push_back(d);
        begin_frame();
        shift_bits(cmd, d, 32, 2, cap);
        check("miso_in_write", cap, 16'h0000);
        repeat (2) @(negedge clk);
        check("led_latency", led, d);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_read(input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] cap;
        rd_q.push_back(exp);
        begin_frame();
        shift_bits(mk_cmd(a, 1'b1, 5'h00, 1'b0, 1'b0), 16'h0000, 32, 3, cap);
        rd_data  = cap;
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        end_frame();
    endtask

    initial begin
        logic [15:0] cap;
        rst_btn = 1'b0;
        cs_n    = 1'b1;
        sclk    = 1'b0;
        mosi    = 1'b0;
        repeat (5) @(negedge clk);
        rst_btn = 1'b1;
        @(negedge clk);
        check("reset_led", led, 16'h0000);
        check("reset_miso", {15'h0000, spi_miso_out}, 16'h0000);
        mon_en = 1'b1;
        spi_read(8'h00, 16'h0000);

        // Basic write then readback
        spi_write(mk_cmd(8'h05, 1'b0, 5'h00, 1'b0, 1'b0), 16'hAAAA);
        spi_read(8'h05, 16'hAAAA);

        // Second address; reads must not disturb led
        spi_write(mk_cmd(8'h42, 1'b0, 5'h00, 1'b0, 1'b0), 16'h1234);
        spi_read(8'h42, 16'h1234);
        spi_read(8'h05, 16'hAAAA);
        check("led_after_reads", led, 16'h1234);

        // Ignored command bits set
        spi_write(mk_cmd(8'h05, 1'b0, 5'h01, 1'b0, 1'b1), 16'h5A5A);
        spi_read(8'h05, 16'h5A5A);

        // Aborted write after 20 bits
        begin_frame();
        shift_bits(mk_cmd(8'h10, 1'b0, 5'h00, 1'b0, 1'b0), 16'hC3C3, 20, 2, cap);
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("led_after_abort", led, 16'h5A5A);
        spi_read(8'h10, 16'h0000);
        spi_write(mk_cmd(8'h10, 1'b0, 5'h00, 1'b0, 1'b0), 16'hC3C3);
        spi_read(8'h10, 16'hC3C3);

        // Reset in the middle of a read of 0x05 (0x5A5A): after 22 rises bit 9 (=1) is out
        led_q.push_back(16'h0000);
        begin_frame();
        shift_bits(mk_cmd(8'h05, 1'b1, 5'h00, 1'b0, 1'b0), 16'h0000, 22, 3, cap);
        check("miso_before_rst", {15'h0000, spi_miso_out}, 16'h0001);
        rst_btn = 1'b0;
        repeat (5) @(negedge clk);
        check("miso_in_rst", {15'h0000, spi_miso_out}, 16'h0000);
        check("led_in_rst", led, 16'h0000);
        rst_btn = 1'b1;
        cs_n    = 1'b1;
        repeat (4) @(negedge clk);
        spi_read(8'h05, 16'h0000);
        spi_read(8'h42, 16'h0000);
        spi_read(8'h10, 16'h0000);
        check("led_after_rst", led, 16'h0000);

        repeat (4) @(negedge clk);
        check("rd_q_drained", 16'(rd_q.size()), 16'h0000);
        check("led_q_drained", 16'(led_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
